// File: rtl/bk_mouse_port.sv
// BK parallel-port mouse: converts PS/2 packet deltas into one-shot direction flags.
// Define BK_MOUSE_ACCUM_EN for saturating motion accumulators; otherwise each packet is thresholded on its own.
module bk_mouse_port #(
  parameter int THRESH = 4,
  parameter int ACC_W  = 10
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [8:0]  pointer_dx,
  input  logic [8:0]  pointer_dy,
  input  logic [7:0]  mouse_counter,
  input  logic        left_btn,
  input  logic        right_btn,
  input  logic        port_write,
  input  logic        port_read,
  input  logic [1:0]  bus_wtbt,
  input  logic [15:0] cpu_dout,
  input  logic        joy_activity,
  output logic [6:0]  mouse_state,
  output logic        mouse_active
);

  // Accumulators must hold a full 9-bit packet delta plus headroom for the threshold.
  if (ACC_W < 10 || THRESH < 1 || THRESH >= (1 << (ACC_W - 2))) begin : g_bad_cfg
    $error("bk_mouse_port: unsupported THRESH/ACC_W combination");
  end

  logic       enable;
  logic       wr_d;
  logic       rd_d;
  logic [7:0] last_cnt;

  logic       wr_lvl_c;
  logic       wr_ev_c;
  logic       rd_fall_c;
  logic       pkt_c;
  logic       take_c;
  logic       clr_c;
  logic [3:0] set_c;
  logic [3:0] flags_c;
  logic       unused_c;

  assign wr_lvl_c  = port_write & bus_wtbt[0];
  assign wr_ev_c   = wr_lvl_c & ~wr_d;
  assign rd_fall_c = rd_d & ~port_read;
  assign pkt_c     = (mouse_counter != last_cnt);
  assign take_c    = enable & pkt_c & ~wr_ev_c;
  assign clr_c     = wr_ev_c & ~cpu_dout[3];
  assign unused_c  = ^{cpu_dout[15:4], cpu_dout[2:0], bus_wtbt[1]};

`ifdef BK_MOUSE_ACCUM_EN
  localparam int unsigned SW = ACC_W + 2;
  localparam logic signed [SW-1:0] ACC_MAX = SW'((1 <<< (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] ACC_MIN = SW'(-(1 <<< (ACC_W - 1)));
  localparam logic signed [SW-1:0] THR     = SW'(THRESH);

  logic signed [ACC_W-1:0] acc_x;
  logic signed [ACC_W-1:0] acc_y;
  logic signed [ACC_W-1:0] acc_x_c;
  logic signed [ACC_W-1:0] acc_y_c;
  logic signed [SW-1:0]    ax_c;
  logic signed [SW-1:0]    ay_c;
  logic signed [SW-1:0]    adj_x_c;
  logic signed [SW-1:0]    adj_y_c;
  logic signed [SW-1:0]    dlt_x_c;
  logic signed [SW-1:0]    dlt_y_c;
  logic signed [8:0]       dx_s;
  logic signed [8:0]       dy_s;

  assign dx_s = pointer_dx;
  assign dy_s = pointer_dy;
  assign ax_c = SW'(acc_x);
  assign ay_c = SW'(acc_y);

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > ACC_MAX) return ACC_W'(ACC_MAX);
    if (v < ACC_MIN) return ACC_W'(ACC_MIN);
    return ACC_W'(v);
  endfunction

  // Threshold the registered accumulators, then fold in this cycle's packet.
  always_comb begin
    set_c   = '0;
    adj_x_c = '0;
    adj_y_c = '0;
    if (enable) begin
      if (!mouse_state[0] && !mouse_state[2]) begin
        if (ay_c >= THR) begin
          set_c[0] = 1'b1;
          adj_y_c  = -THR;
        end else if (ay_c <= -THR) begin
          set_c[2] = 1'b1;
          adj_y_c  = THR;
        end
      end
      if (!mouse_state[1] && !mouse_state[3]) begin
        if (ax_c >= THR) begin
          set_c[1] = 1'b1;
          adj_x_c  = -THR;
        end else if (ax_c <= -THR) begin
          set_c[3] = 1'b1;
          adj_x_c  = THR;
        end
      end
    end
    dlt_x_c = take_c ? SW'(dx_s) : '0;
    dlt_y_c = take_c ? SW'(dy_s) : '0;
    acc_x_c = sat(ax_c + adj_x_c + dlt_x_c);
    acc_y_c = sat(ay_c + adj_y_c + dlt_y_c);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n || clr_c) begin
      acc_x <= '0;
      acc_y <= '0;
    end else begin
      acc_x <= acc_x_c;
      acc_y <= acc_y_c;
    end
  end
`else
  // Per-packet thresholding; residual motion is dropped.
  always_comb begin
    set_c = '0;
    if (take_c) begin
      if (!mouse_state[0] && !mouse_state[2]) begin
        if (!pointer_dy[8] && (pointer_dy > 9'd3))
          set_c[0] = 1'b1;
        else if (pointer_dy[8] && ((~pointer_dy) > 9'd2))
          set_c[2] = 1'b1;
      end
      if (!mouse_state[1] && !mouse_state[3]) begin
        if (!pointer_dx[8] && (pointer_dx > 9'd3))
          set_c[1] = 1'b1;
        else if (pointer_dx[8] && ((~pointer_dx) > 9'd2))
          set_c[3] = 1'b1;
      end
    end
  end
`endif

  // Read-clear loses to a new flag; a disabling write clears everything.
  always_comb begin
    flags_c = mouse_state[3:0];
    if (rd_fall_c) flags_c = '0;
    flags_c = flags_c | set_c;
    if (clr_c) flags_c = '0;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      mouse_state  <= '0;
      mouse_active <= 1'b0;
      enable       <= 1'b0;
      wr_d         <= 1'b0;
      rd_d         <= 1'b0;
      last_cnt     <= mouse_counter;
    end else begin
      wr_d        <= wr_lvl_c;
      rd_d        <= port_read;
      last_cnt    <= mouse_counter;
      mouse_state <= {right_btn, left_btn, 1'b0, flags_c};
      if (wr_ev_c) enable <= cpu_dout[3];
      if (pkt_c)
        mouse_active <= 1'b1;
      else if (joy_activity)
        mouse_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bk_mouse_port.sv
// Scoreboard bench for bk_mouse_port: a behavioural model pushes the expected port word every clock.
module tb_bk_mouse_port;
  localparam int TH   = 4;
  localparam int AMAX = 511;
  localparam int AMIN = -512;

  logic        clk_sys;
  logic        reset_n;
  logic [8:0]  pointer_dx;
  logic [8:0]  pointer_dy;
  logic [7:0]  mouse_counter;
  logic        left_btn;
  logic        right_btn;
  logic        port_write;
  logic        port_read;
  logic [1:0]  bus_wtbt;
  logic [15:0] cpu_dout;
  logic        joy_activity;
  logic [6:0]  mouse_state;
  logic        mouse_active;

  int    n_chk  = 0;
  int    n_fail = 0;
  string phase  = "init";
  logic [7:0] sb_q[$];

  logic [6:0] m_ms;
  logic       m_act;
  logic       m_en;
  logic       m_wd;
  logic       m_rd;
  logic [7:0] m_lc;
`ifdef BK_MOUSE_ACCUM_EN
  int m_ax;
  int m_ay;
`endif

  bk_mouse_port dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .pointer_dx   (pointer_dx),
    .pointer_dy   (pointer_dy),
    .mouse_counter(mouse_counter),
    .left_btn     (left_btn),
    .right_btn    (right_btn),
    .port_write   (port_write),
    .port_read    (port_read),
    .bus_wtbt     (bus_wtbt),
    .cpu_dout     (cpu_dout),
    .joy_activity (joy_activity),
    .mouse_state  (mouse_state),
    .mouse_active (mouse_active)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: evaluates one clock of behaviour from the inputs the bench drives.
  always @(posedge clk_sys) begin : model
    logic       w, pk, rf;
    logic [3:0] f;
    int         dx, dy;
`ifdef BK_MOUSE_ACCUM_EN
    int nx, ny;
`endif
    w  = port_write && bus_wtbt[0] && !m_wd;
    pk = (mouse_counter != m_lc);
    rf = m_rd && !port_read;
    dx = int'($signed(pointer_dx));
    dy = int'($signed(pointer_dy));
    if (!reset_n) begin
      m_ms = '0; m_act = 1'b0; m_en = 1'b0; m_wd = 1'b0; m_rd = 1'b0;
`ifdef BK_MOUSE_ACCUM_EN
      m_ax = 0; m_ay = 0;
`endif
    end else begin
      f = m_ms[3:0];
      if (rf) f = '0;
`ifdef BK_MOUSE_ACCUM_EN
      nx = m_ax; ny = m_ay;
      if (m_en) begin
        if (!m_ms[0] && !m_ms[2]) begin
          if (m_ay >= TH) begin f[0] = 1'b1; ny -= TH; end
          else if (m_ay <= -TH) begin f[2] = 1'b1; ny += TH; end
        end
        if (!m_ms[1] && !m_ms[3]) begin
          if (m_ax >= TH) begin f[1] = 1'b1; nx -= TH; end
          else if (m_ax <= -TH) begin f[3] = 1'b1; nx += TH; end
        end
        if (pk && !w) begin nx += dx; ny += dy; end
        if (nx > AMAX) nx = AMAX;
        if (nx < AMIN) nx = AMIN;
        if (ny > AMAX) ny = AMAX;
        if (ny < AMIN) ny = AMIN;
      end
      m_ax = nx; m_ay = ny;
`else
      if (m_en && pk && !w) begin
        if (!m_ms[0] && !m_ms[2]) begin
          if (dy >= TH) f[0] = 1'b1;
          else if (dy <= -TH) f[2] = 1'b1;
        end
        if (!m_ms[1] && !m_ms[3]) begin
          if (dx >= TH) f[1] = 1'b1;
          else if (dx <= -TH) f[3] = 1'b1;
        end
      end
`endif
      if (w) begin
        m_en = cpu_dout[3];
        if (!cpu_dout[3]) begin
          f = '0;
`ifdef BK_MOUSE_ACCUM_EN
          m_ax = 0; m_ay = 0;
`endif
        end
      end
      m_ms = {right_btn, left_btn, 1'b0, f};
      if (pk) m_act = 1'b1;
      else if (joy_activity) m_act = 1'b0;
      m_wd = port_write && bus_wtbt[0];
      m_rd = port_read;
    end
    m_lc = mouse_counter;
    sb_q.push_back({m_act, m_ms});
  end

  // Advance one clock and compare the DUT against the entry the model produced for it.
  task automatic step();
    logic [7:0] e;
    @(posedge clk_sys);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk(phase, 32'({mouse_active, mouse_state}), 32'(e));
    end else begin
      chk("sb_empty", 32'(sb_q.size()), 32'd1);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [15:0] d, input logic [1:0] be);
    port_write = 1'b1; bus_wtbt = be; cpu_dout = d;
    step();
    port_write = 1'b0;
    step();
  endtask

  task automatic rd();
    port_read = 1'b1;
    step();
    port_read = 1'b0;
    step();
  endtask

  task automatic pkt(input logic [8:0] dx, input logic [8:0] dy);
    pointer_dx = dx; pointer_dy = dy;
    mouse_counter = mouse_counter + 8'd1;
    step();
  endtask

  initial begin
    reset_n = 1'b0; pointer_dx = '0; pointer_dy = '0; mouse_counter = 8'h00;
    left_btn = 1'b0; right_btn = 1'b0; port_write = 1'b0; port_read = 1'b0;
    bus_wtbt = 2'b00; cpu_dout = '0; joy_activity = 1'b0;

    phase = "reset";
    pointer_dy = 9'd50;
    repeat (3) begin
      mouse_counter = mouse_counter + 8'd1;
      step();
    end
    chk("rst_state", 32'(mouse_state), 32'h0);
    chk("rst_active", 32'(mouse_active), 32'h0);
    reset_n = 1'b1;
    steps(3);
    chk("rst_stale", 32'(mouse_state), 32'h0);

    phase = "accumulate";
    left_btn = 1'b1;
    wr(16'h0008, 2'b01);
    pkt(9'h000, 9'h002);
    pkt(9'h000, 9'h002);
    steps(3);
    pkt(9'h1F7, 9'h000);
    steps(3);
    rd(); steps(3);
    rd(); steps(3);
    left_btn = 1'b0; right_btn = 1'b1;
    rd(); steps(2);

    phase = "saturate";
    repeat (10) pkt(9'h000, 9'h0FF);
    steps(3);
    repeat (5) begin rd(); steps(2); end

    phase = "disable";
    pkt(9'h005, 9'h1F0);
    steps(3);
    wr(16'h0000, 2'b01);
    pkt(9'h009, 9'h009);
    steps(3);
    chk("dis_flags", 32'(mouse_state[3:0]), 32'h0);
    chk("dis_active", 32'(mouse_active), 32'h1);
    joy_activity = 1'b1; step(); joy_activity = 1'b0; step();
    chk("joy_clear", 32'(mouse_active), 32'h0);

`ifndef BK_MOUSE_ACCUM_EN
    phase = "per_packet";
    wr(16'h0008, 2'b01);
    pkt(9'h000, 9'h003);
    chk("dy_p3", 32'(mouse_state[3:0]), 32'h0);
    pkt(9'h000, 9'h1FC);
    chk("dy_m4", 32'(mouse_state[3:0]), 32'h4);
    pkt(9'h1FD, 9'h000);
    chk("dx_m3", 32'(mouse_state[3:0]), 32'h4);
    pkt(9'h004, 9'h1F0);
    chk("dx_p4", 32'(mouse_state[3:0]), 32'h6);
    rd();
    chk("rd_clr", 32'(mouse_state[3:0]), 32'h0);
`endif

    phase = "collide";
    wr(16'h0000, 2'b01);
    port_write = 1'b1; bus_wtbt = 2'b01; cpu_dout = 16'h0008;
    pointer_dx = 9'd0; pointer_dy = 9'd100;
    mouse_counter = mouse_counter + 8'd1;
    step();
    port_write = 1'b0;
    steps(3);
    chk("wr_beats_pkt", 32'(mouse_state[3:0]), 32'h0);
    wr(16'h0000, 2'b10);
    pkt(9'h000, 9'h032);
    steps(3);
    port_read = 1'b1; step();
    port_read = 1'b0;
    pkt(9'h014, 9'h000);
    steps(3);
    joy_activity = 1'b1;
    mouse_counter = mouse_counter + 8'd1;
    step();
    chk("joy_pkt", 32'(mouse_active), 32'h1);
    joy_activity = 1'b0;
    steps(2);

    phase = "random";
    repeat (1500) begin
      left_btn   = 1'($urandom_range(0, 1));
      right_btn  = 1'($urandom_range(0, 1));
      port_write = ($urandom_range(0, 9) == 0);
      bus_wtbt   = 2'($urandom_range(0, 3));
      cpu_dout   = 16'($urandom) | (($urandom_range(0, 7) != 0) ? 16'h0008 : 16'h0000);
      port_read  = ($urandom_range(0, 3) == 0);
      joy_activity = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 5) == 0) begin
          pointer_dx = 9'($urandom);
          pointer_dy = 9'($urandom);
        end else begin
          pointer_dx = 9'($urandom_range(0, 24)) - 9'd12;
          pointer_dy = 9'($urandom_range(0, 24)) - 9'd12;
        end
        mouse_counter = mouse_counter + 8'd1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
